tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Queued note player: accepts (tone, duration) commands over a valid/ready handshake and drives a square wave at the selected C-major pitch for the commanded time.
- Inserts a fixed silent gap after each note; holds one pending note so notes play back-to-back without bubbles.
- Sits between game/event logic and the speaker pin; successor of the single-tone generator, adding clock-frequency parametrisation, timed notes, queuing and abort.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz; all pitch and ms counts derive from it at elaboration.
- DUR_W, 10, width of the note duration field, in ms.
- GAP_MS, 20, silent gap after every note, in ms; 0 disables the gap.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- note_valid  in  1  note command valid.
- note_ready  out  1  pending slot free; a note is accepted when valid&&ready on a rising clk.
- note_tone  in  4  tone code: 0=rest, 1..15 = C3,D3,E3,F3,G3,A3,B3,C4,D4,E4,F4,G4,A4,B4,C5.
- note_dur  in  DUR_W  note length in ms; 0 is treated as 1.
- abort  in  1  synchronous flush of the active and pending notes.
- out  out  1  square-wave audio output.
- busy  out  1  high in PLAY or GAP.
- note_done  out  1  one-cycle pulse at the end of each PLAY phase.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, out=0, busy=0, note_done=0, note_ready=1, pending slot empty, all counters 0.
- Pitch: HP(t) = floor(CLK_FREQ / (2*FREQ(t))), with FREQ from {131,147,165,175,196,220,247,262,294,330,349,392,440,494,523} Hz. The period counter counts 0..HP-1; out toggles when the count reaches HP-1. Counter width = clog2(HP(C3)).
- Rest tone (0): out held at 0 for the full duration; timing otherwise identical to a pitched note.
- ms tick: a free prescaler of CLK_FREQ/1000 cycles, reset to 0 on every note start. PLAY lasts max(dur,1)*CLK_FREQ/1000 cycles exactly.
- States:
  - IDLE: an accepted note loads directly into the active register. Next state PLAY, period counter=0, out=0.
  - PLAY: out toggles per the pitch rule. On the final cycle: note_done=1, out forced to 0 on the next cycle, next state GAP (or, if GAP_MS=0, see the GAP exit rule).
  - GAP: out=0 for GAP_MS*CLK_FREQ/1000 cycles. On exit: pending valid -> move it to active, clear the slot, state PLAY; otherwise state IDLE.
- note_ready is the registered inverse of pending-valid. In IDLE it is 1 and the note bypasses the slot.
- Accepting while the slot drains in the same cycle is legal; the new note lands in the slot.
- abort (priority over everything except reset): next cycle state=IDLE, out=0, pending cleared, no note_done. note_ready is forced 0 during any cycle with abort=1, so no note is accepted.
- note_tone and note_dur are sampled only at acceptance; later changes have no effect.

Decomposition:
- Package tone_pkg:
  - tone code constants TONE_NONE..TONE_C5;
  - frequency table;
  - function half_period(tone, clk_freq);
  - state enum {IDLE, PLAY, GAP}.
- Sub-module tick_gen: parametrised prescaler (DIV) with sync clear, one-cycle tick output; instantiated once for the ms tick.

Test Plan (CLK_FREQ=1000000, GAP_MS=2 unless stated):
- Reset and idle: rst_n low mid-note -> out=0, busy=0, note_ready=1 immediately (asynchronously); no toggles for 10000 cycles after release.
- Single A4 note, dur=3: HP=1136. out toggles every 1136 cycles, first toggle 1136 cycles after acceptance. note_done pulses 3000 cycles after acceptance. out=0 for 2000 cycles, then IDLE.
- Queuing: C5 dur=1 accepted, then G3 dur=1 immediately -> note_ready drops to 0. G3 (HP=2551) starts exactly 2000 cycles after C5's note_done; note_ready returns to 1 at that point.
- Rest and zero duration: tone=0 dur=0 -> out stays 0, note_done 1000 cycles after acceptance, busy high for 3000 cycles.
- Abort: abort during PLAY of E4 with a note pending -> out=0 and busy=0 the next cycle, no note_done, pending never plays. A note_valid held high during the abort cycle is not accepted.
- GAP_MS=0 back-to-back: two D4 notes dur=1 -> second PLAY starts the cycle after the first note_done, with no extra idle cycle.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer: tone codes, pitch table,
// half-period helper and the player state encoding.
package tone_pkg;

   typedef logic [3:0] tone_t;

   localparam tone_t TONE_NONE = 4'd0;
   localparam tone_t TONE_C3   = 4'd1;
   localparam tone_t TONE_D3   = 4'd2;
   localparam tone_t TONE_E3   = 4'd3;
   localparam tone_t TONE_F3   = 4'd4;
   localparam tone_t TONE_G3   = 4'd5;
   localparam tone_t TONE_A3   = 4'd6;
   localparam tone_t TONE_B3   = 4'd7;
   localparam tone_t TONE_C4   = 4'd8;
   localparam tone_t TONE_D4   = 4'd9;
   localparam tone_t TONE_E4   = 4'd10;
   localparam tone_t TONE_F4   = 4'd11;
   localparam tone_t TONE_G4   = 4'd12;
   localparam tone_t TONE_A4   = 4'd13;
   localparam tone_t TONE_B4   = 4'd14;
   localparam tone_t TONE_C5   = 4'd15;

   // Entry 0 is the rest code and carries no pitch.
   localparam int FREQ_TABLE [16] = '{
      0, 131, 147, 165, 175, 196, 220, 247,
      262, 294, 330, 349, 392, 440, 494, 523
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Clock cycles per half period of the square wave; 0 for the rest code.
   function automatic int half_period(input tone_t tone, input int clk_freq);
      if (tone == TONE_NONE) begin
         return 0;
      end
      return clk_freq / (2 * FREQ_TABLE[tone]);
   endfunction

endpackage

// File: rtl/tone_sequencer_tick_gen.sv
// Free-running prescaler that emits a one-cycle tick every DIV clocks;
// a synchronous clear restarts the count from zero.
module tick_gen #(
   parameter int DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == CNT_W'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tone_sequencer.sv
// Queued note player: one active note plus one pending slot, each note
// followed by a silent gap, square-wave output at the selected pitch.
module tone_sequencer
   import tone_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int DUR_W    = 10,
   parameter int GAP_MS   = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             note_valid,
   output logic             note_ready,
   input  logic [3:0]       note_tone,
   input  logic [DUR_W-1:0] note_dur,
   input  logic             abort,
   output logic             out,
   output logic             busy,
   output logic             note_done
);

   localparam int MS_DIV = CLK_FREQ / 1000;
   localparam int PER_W  = $clog2(half_period(TONE_C3, CLK_FREQ));
   localparam int GAP_W  = $clog2(GAP_MS + 1);
   localparam int MS_W   = (DUR_W > GAP_W) ? DUR_W : GAP_W;
   localparam logic [MS_W-1:0] GAP_LAST = MS_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);

   // Per-tone terminal count of the period counter, folded at elaboration.
   logic [PER_W-1:0] hp_last_tab [16];

   for (genvar gi = 0; gi < 16; gi++) begin : g_hp
      localparam int HP = half_period(tone_t'(gi), CLK_FREQ);
      assign hp_last_tab[gi] = PER_W'((HP > 0) ? HP - 1 : 0);
   end

   state_t           state_q,      state_d;
   tone_t            act_tone_q,   act_tone_d;
   logic [DUR_W-1:0] act_last_q,   act_last_d;
   logic             pend_valid_q, pend_valid_d;
   tone_t            pend_tone_q,  pend_tone_d;
   logic [DUR_W-1:0] pend_last_q,  pend_last_d;
   logic [MS_W-1:0]  ms_cnt_q,     ms_cnt_d;
   logic [PER_W-1:0] per_cnt_q,    per_cnt_d;
   logic             out_q,        out_d;
   logic             ready_q,      ready_d;

   logic             ms_tick;
   logic             tick_clr;
   logic             accept;
   logic             play_last;
   logic             seq_end;
   logic             load_new;
   logic             load_pend;
   logic [DUR_W-1:0] dur_last;
   logic [PER_W-1:0] hp_last;

   tick_gen #(
      .DIV (MS_DIV)
   ) u_ms_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tick_clr),
      .tick  (ms_tick)
   );

   // A zero duration plays for one millisecond.
   assign dur_last  = (note_dur == '0) ? '0 : note_dur - DUR_W'(1);
   assign hp_last   = hp_last_tab[act_tone_q];
   assign accept    = note_valid && note_ready;
   assign play_last = (state_q == PLAY) && ms_tick && (ms_cnt_q == MS_W'(act_last_q));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         act_tone_q   <= TONE_NONE;
         act_last_q   <= '0;
         pend_valid_q <= 1'b0;
         pend_tone_q  <= TONE_NONE;
         pend_last_q  <= '0;
         ms_cnt_q     <= '0;
         per_cnt_q    <= '0;
         out_q        <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         act_tone_q   <= act_tone_d;
         act_last_q   <= act_last_d;
         pend_valid_q <= pend_valid_d;
         pend_tone_q  <= pend_tone_d;
         pend_last_q  <= pend_last_d;
         ms_cnt_q     <= ms_cnt_d;
         per_cnt_q    <= per_cnt_d;
         out_q        <= out_d;
         ready_q      <= ready_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      act_tone_d   = act_tone_q;
      act_last_d   = act_last_q;
      pend_valid_d = pend_valid_q;
      pend_tone_d  = pend_tone_q;
      pend_last_d  = pend_last_q;
      ms_cnt_d     = ms_cnt_q;
      per_cnt_d    = per_cnt_q;
      out_d        = out_q;
      tick_clr     = 1'b0;
      seq_end      = 1'b0;
      load_new     = 1'b0;
      load_pend    = 1'b0;

      if (abort) begin
         state_d      = IDLE;
         pend_valid_d = 1'b0;
         ms_cnt_d     = '0;
         per_cnt_d    = '0;
         out_d        = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  load_new = 1'b1;
               end
            end
            PLAY: begin
               if (ms_tick) begin
                  ms_cnt_d = ms_cnt_q + MS_W'(1);
               end
               if (act_tone_q == TONE_NONE) begin
                  out_d = 1'b0;
               end else if (per_cnt_q == hp_last) begin
                  per_cnt_d = '0;
                  out_d     = ~out_q;
               end else begin
                  per_cnt_d = per_cnt_q + PER_W'(1);
               end
               if (play_last) begin
                  out_d     = 1'b0;
                  per_cnt_d = '0;
                  ms_cnt_d  = '0;
                  if (GAP_MS == 0) begin
                     seq_end = 1'b1;
                  end else begin
                     state_d = GAP;
                  end
               end
            end
            GAP: begin
               out_d = 1'b0;
               if (ms_tick) begin
                  if (ms_cnt_q == GAP_LAST) begin
                     seq_end = 1'b1;
                  end else begin
                     ms_cnt_d = ms_cnt_q + MS_W'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         // At the end of a note the pending slot wins; a note arriving in
         // that same cycle with the slot empty goes straight to active.
         if (seq_end) begin
            if (pend_valid_q) begin
               load_pend = 1'b1;
            end else if (accept) begin
               load_new = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end

         if (load_pend) begin
            act_tone_d   = pend_tone_q;
            act_last_d   = pend_last_q;
            pend_valid_d = 1'b0;
         end
         if (accept && !load_new) begin
            pend_valid_d = 1'b1;
            pend_tone_d  = note_tone;
            pend_last_d  = dur_last;
         end
         if (load_new) begin
            act_tone_d = note_tone;
            act_last_d = dur_last;
         end
         if (load_new || load_pend) begin
            state_d   = PLAY;
            ms_cnt_d  = '0;
            per_cnt_d = '0;
            out_d     = 1'b0;
            tick_clr  = 1'b1;
         end
      end

      ready_d = ~pend_valid_d;
   end

   always_comb begin
      note_ready = ready_q & ~abort;
      busy       = (state_q != IDLE);
      note_done  = play_last & ~abort;
      out        = out_q;
   end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench: stimulus pushes expected event cycles, a negedge
// monitor pops and compares on every note_done, out edge and busy fall.
module tb_tone_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] nv = '0;
   logic [1:0] ab = '0;
   logic [3:0] nt [2];
   logic [9:0] nd [2];
   logic [1:0] rdy, outw, busyw, donew;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit mon_en = 1'b0;
   logic [1:0] out_p = '0;
   logic [1:0] busy_p = '0;

   // Queue index = instance*3 + kind; kind 0=note_done, 1=out edge, 2=busy fall.
   int exp_q [6][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tone_sequencer #(.CLK_FREQ(1000000), .DUR_W(10), .GAP_MS(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .note_valid (nv[0]),
      .note_ready (rdy[0]),
      .note_tone  (nt[0]),
      .note_dur   (nd[0]),
      .abort      (ab[0]),
      .out        (outw[0]),
      .busy       (busyw[0]),
      .note_done  (donew[0])
   );

   tone_sequencer #(.CLK_FREQ(1000000), .DUR_W(10), .GAP_MS(0)) dut_nogap (
      .clk        (clk),
      .rst_n      (rst_n),
      .note_valid (nv[1]),
      .note_ready (rdy[1]),
      .note_tone  (nt[1]),
      .note_dur   (nd[1]),
      .abort      (ab[1]),
      .out        (outw[1]),
      .busy       (busyw[1]),
      .note_done  (donew[1])
   );

   function automatic string kname(input int k);
      case (k)
         0:       return "note_done";
         1:       return "out_edge";
         default: return "busy_fall";
      endcase
   endfunction

   task automatic expect_evt(input int inst, input int kind, input int c);
      exp_q[inst*3 + kind].push_back(c);
   endtask

   task automatic check_evt(input int inst, input int kind);
      int e;
      vectors++;
      if (exp_q[inst*3 + kind].size() == 0) begin
         miscompares++;
         $display("FAIL inst%0d %s unexpected: got event at cycle %0d, expected none",
                  inst, kname(kind), cyc);
      end else begin
         e = exp_q[inst*3 + kind].pop_front();
         if (e != cyc) begin
            miscompares++;
            $display("FAIL inst%0d %s: got cycle %0d, expected cycle %0d",
                     inst, kname(kind), cyc, e);
         end else begin
            $display("inst%0d %s at cycle %0d ok", inst, kname(kind), cyc);
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("%s = %0d ok", name, act);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (mon_en) begin
            if (donew[i]) check_evt(i, 0);
            if (outw[i] !== out_p[i]) check_evt(i, 1);
            if (busy_p[i] && !busyw[i]) check_evt(i, 2);
         end
         out_p[i]  <= outw[i];
         busy_p[i] <= busyw[i];
      end
   end

   // Issue one note; returns at the negedge just after the accepting edge.
   task automatic send(input int inst, input int tone, input int dur, output int a);
      int t;
      nv[inst] = 1'b1;
      nt[inst] = 4'(tone);
      nd[inst] = 10'(dur);
      #1;
      t = 0;
      while (!rdy[inst] && t < 20000) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (!rdy[inst]) begin
         vectors++;
         miscompares++;
         $display("FAIL inst%0d send timeout: note_ready stayed %0d, expected 1", inst, rdy[inst]);
      end
      @(negedge clk);
      a = cyc;
      nv[inst] = 1'b0;
      nt[inst] = 4'hA;
      nd[inst] = 10'h3FF;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic wait_idle(input int inst);
      int t;
      t = 0;
      @(negedge clk);
      while (busyw[inst] && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (busyw[inst]) begin
         vectors++;
         miscompares++;
         $display("FAIL inst%0d idle timeout: busy got 1, expected 0", inst);
      end
      repeat (10) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, a2, x;
      nt[0] = '0; nt[1] = '0; nd[0] = '0; nd[1] = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset out", outw[0], 0);
      chk("reset busy", busyw[0], 0);
      chk("reset note_ready", rdy[0], 1);
      chk("reset note_done", donew[0], 0);
      chk("reset note_ready nogap", rdy[1], 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Asynchronous reset in the middle of a sounding A4
      send(0, 13, 3, a);
      wait_until(a + 1500);
      chk("A4 out high before reset", outw[0], 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset out", outw[0], 0);
      chk("async reset busy", busyw[0], 0);
      chk("async reset note_ready", rdy[0], 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      repeat (10000) @(negedge clk);
      chk("post-reset idle busy", busyw[0], 0);
      chk("post-reset idle out", outw[0], 0);

      // Single A4, 3 ms: HP=1136
      send(0, 13, 3, a);
      expect_evt(0, 1, a + 1136);
      expect_evt(0, 1, a + 2272);
      expect_evt(0, 0, a + 2999);
      expect_evt(0, 2, a + 5000);
      wait_idle(0);

      // Queuing: C5 (HP=956) then G3 (HP=2551) into the slot
      send(0, 15, 1, a);
      send(0, 5, 1, x);
      #1;
      chk("queue note_ready after second accept", rdy[0], 0);
      a2 = a + 3000;
      expect_evt(0, 1, a + 956);
      expect_evt(0, 0, a + 999);
      expect_evt(0, 1, a + 1000);
      expect_evt(0, 0, a2 + 999);
      expect_evt(0, 2, a2 + 3000);
      wait_until(a2 - 1);
      chk("queue note_ready during gap", rdy[0], 0);
      wait_until(a2);
      chk("queue note_ready at G3 start", rdy[0], 1);
      wait_idle(0);

      // Rest with zero duration
      send(0, 0, 0, a);
      expect_evt(0, 0, a + 999);
      expect_evt(0, 2, a + 3000);
      wait_idle(0);

      // Abort during E4 (HP=1515) with C4 pending; valid held in abort cycle
      send(0, 10, 3, a);
      send(0, 8, 2, x);
      expect_evt(0, 1, a + 1515);
      expect_evt(0, 1, a + 2001);
      expect_evt(0, 2, a + 2001);
      wait_until(a + 2000);
      ab[0] = 1'b1;
      nv[0] = 1'b1;
      nt[0] = 4'd3;
      nd[0] = 10'd1;
      #1;
      chk("abort note_ready", rdy[0], 0);
      @(negedge clk);
      ab[0] = 1'b0;
      nv[0] = 1'b0;
      #1;
      chk("after abort busy", busyw[0], 0);
      chk("after abort out", outw[0], 0);
      chk("after abort note_ready", rdy[0], 1);
      repeat (5000) @(negedge clk);
      chk("abort pending never plays", busyw[0], 0);

      // Abort in IDLE with valid high: nothing is accepted
      ab[0] = 1'b1;
      nv[0] = 1'b1;
      #1;
      chk("idle abort note_ready", rdy[0], 0);
      @(negedge clk);
      ab[0] = 1'b0;
      nv[0] = 1'b0;
      #1;
      chk("idle abort busy", busyw[0], 0);
      repeat (20) @(negedge clk);

      // GAP_MS=0: two D4 notes (HP=1700) back to back
      send(1, 9, 1, a);
      send(1, 9, 1, x);
      expect_evt(1, 0, a + 999);
      expect_evt(1, 0, a + 1999);
      expect_evt(1, 2, a + 2000);
      wait_until(a + 1000);
      chk("nogap second note busy", busyw[1], 1);
      chk("nogap note_ready after drain", rdy[1], 1);
      wait_idle(1);

      for (int q = 0; q < 6; q++) begin
         vectors++;
         if (exp_q[q].size() != 0) begin
            miscompares++;
            $display("FAIL inst%0d %s missing: got %0d events, expected 0 outstanding (next cycle %0d)",
                     q / 3, kname(q % 3), exp_q[q].size(), exp_q[q][0]);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
